// File: rtl/rfft_4pt_ctrl.sv
// Block sequencer for the 4-point real-FFT butterfly: read 4 words, two mux stages, write back 4 words.
// Optional feature macro: RFFT_CTRL_BITREV_EN (bit-reversed write-back addressing).

module rfft_4pt_ctrl_lane #(
  parameter int ADDR_BIT = 3,
  parameter int LANE     = 0
) (
  input  logic [ADDR_BIT-1:0] base,
  output logic [ADDR_BIT-1:0] rd_addr,
  output logic [ADDR_BIT-1:0] wr_addr
);
  assign rd_addr = base + ADDR_BIT'(LANE);

`ifdef RFFT_CTRL_BITREV_EN
  // Write to the mirrored address so results land in natural order.
  always_comb begin
    wr_addr = '0;
    for (int i = 0; i < ADDR_BIT; i++) wr_addr[i] = rd_addr[ADDR_BIT-1-i];
  end
`else
  assign wr_addr = rd_addr;
`endif
endmodule

module rfft_4pt_ctrl #(
  parameter int ADDR_BIT   = 3,
  parameter int MEM_HEIGHT = 8,
  parameter int TW_BIT     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  bypass,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [4*ADDR_BIT-1:0] addr_read,
  output logic                  wr_en,
  output logic [4*ADDR_BIT-1:0] addr_write,
  output logic                  m0,
  output logic                  m11,
  output logic [1:0]            m12,
  output logic [1:0]            m13,
  output logic                  m14,
  output logic                  m21,
  output logic                  m22,
  output logic                  m23,
  output logic                  m24,
  output logic                  bypass_en,
  output logic [TW_BIT-1:0]     tw_idx
);
  localparam int NUM_LANES = 4;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD   = 3'd1;
  localparam logic [2:0] S1   = 3'd2;
  localparam logic [2:0] S2   = 3'd3;
  localparam logic [2:0] WR   = 3'd4;
  localparam logic [2:0] DONE = 3'd5;

  localparam logic [ADDR_BIT-1:0] LAST_BASE = ADDR_BIT'(MEM_HEIGHT - 4);
  localparam logic [ADDR_BIT-1:0] BLK_STEP  = ADDR_BIT'(NUM_LANES);

  typedef struct packed {
    logic       m0;
    logic       m11;
    logic [1:0] m12;
    logic [1:0] m13;
    logic       m14;
    logic       m21;
    logic       m22;
    logic       m23;
    logic       m24;
  } sel_t;

  logic [2:0]          state, state_nxt;
  logic [ADDR_BIT-1:0] base, base_nxt;
  logic                byp, byp_nxt;
  logic [ADDR_BIT-1:0] blk_idx;
  sel_t                sel_nxt, sel_q;
  logic [TW_BIT-1:0]   tw_nxt;

  logic [NUM_LANES-1:0][ADDR_BIT-1:0] rd_lane;
  logic [NUM_LANES-1:0][ADDR_BIT-1:0] wr_lane;

  // Abort wins over everything outside IDLE; in IDLE it only masks start.
  always_comb begin
    state_nxt = state;
    base_nxt  = base;
    byp_nxt   = byp;
    if (state != IDLE && abort) begin
      state_nxt = IDLE;
      base_nxt  = '0;
    end else begin
      case (state)
        IDLE: if (start && !abort) begin
          state_nxt = RD;
          base_nxt  = '0;
          byp_nxt   = bypass;
        end
        RD:   state_nxt = S1;
        S1:   state_nxt = S2;
        S2:   state_nxt = WR;
        WR: begin
          if (base == LAST_BASE) begin
            state_nxt = DONE;
            base_nxt  = '0;
          end else begin
            state_nxt = RD;
            base_nxt  = base + BLK_STEP;
          end
        end
        DONE:    state_nxt = IDLE;
        default: begin
          state_nxt = IDLE;
          base_nxt  = '0;
        end
      endcase
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      rfft_4pt_ctrl_lane #(.ADDR_BIT(ADDR_BIT), .LANE(g)) u_lane (
        .base    (base_nxt),
        .rd_addr (rd_lane[g]),
        .wr_addr (wr_lane[g])
      );
    end
  endgenerate

  assign blk_idx = base_nxt >> 2;

  always_comb begin
    sel_nxt = '0;
    tw_nxt  = '0;
    if (!byp_nxt) begin
      if (state_nxt == S1) begin
        sel_nxt.m0  = 1'b1;
        sel_nxt.m11 = 1'b1;
        sel_nxt.m12 = 2'b01;
        sel_nxt.m13 = 2'b10;
        sel_nxt.m14 = 1'b1;
      end
      if (state_nxt == S2) begin
        sel_nxt.m21 = 1'b1;
        sel_nxt.m22 = 1'b1;
        sel_nxt.m23 = 1'b1;
        sel_nxt.m24 = 1'b1;
        tw_nxt      = TW_BIT'(blk_idx);
      end
    end
  end

  // Outputs are registered from the next-state decode so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      base       <= '0;
      byp        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_en      <= 1'b0;
      addr_read  <= '0;
      wr_en      <= 1'b0;
      addr_write <= '0;
      sel_q      <= '0;
      bypass_en  <= 1'b0;
      tw_idx     <= '0;
    end else begin
      state      <= state_nxt;
      base       <= base_nxt;
      byp        <= byp_nxt;
      busy       <= (state_nxt != IDLE);
      done       <= (state_nxt == DONE);
      rd_en      <= (state_nxt == RD);
      addr_read  <= (state_nxt == RD) ? rd_lane : '0;
      wr_en      <= (state_nxt == WR);
      addr_write <= (state_nxt == WR) ? wr_lane : '0;
      sel_q      <= sel_nxt;
      bypass_en  <= byp_nxt && (state_nxt == S1 || state_nxt == S2 || state_nxt == WR);
      tw_idx     <= tw_nxt;
    end
  end

  assign m0  = sel_q.m0;
  assign m11 = sel_q.m11;
  assign m12 = sel_q.m12;
  assign m13 = sel_q.m13;
  assign m14 = sel_q.m14;
  assign m21 = sel_q.m21;
  assign m22 = sel_q.m22;
  assign m23 = sel_q.m23;
  assign m24 = sel_q.m24;
endmodule

// File: tb/tb_rfft_4pt_ctrl.sv
// Self-checking bench for rfft_4pt_ctrl: per-cycle expected records queued at start, compared on negedge.
module tb_rfft_4pt_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, start, bypass, abort;
  logic        busy, done, rd_en, wr_en;
  logic [11:0] addr_read, addr_write;
  logic        m0, m11, m14, m21, m22, m23, m24, bypass_en;
  logic [1:0]  m12, m13, tw_idx;

  always #5 clk = ~clk;

  rfft_4pt_ctrl #(.ADDR_BIT(3), .MEM_HEIGHT(8), .TW_BIT(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bypass(bypass), .abort(abort),
    .busy(busy), .done(done), .rd_en(rd_en), .addr_read(addr_read),
    .wr_en(wr_en), .addr_write(addr_write),
    .m0(m0), .m11(m11), .m12(m12), .m13(m13), .m14(m14),
    .m21(m21), .m22(m22), .m23(m23), .m24(m24),
    .bypass_en(bypass_en), .tw_idx(tw_idx)
  );

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        rd;
    logic [11:0] ar;
    logic        wr;
    logic [11:0] aw;
    logic [10:0] sel;  // {m0,m11,m12,m13,m14,m21,m22,m23,m24}
    logic        byp;
    logic [1:0]  tw;
  } exp_t;

  localparam logic [10:0] SEL_S1 = 11'b1_1_01_10_1_0000;
  localparam logic [10:0] SEL_S2 = 11'b0_0_00_00_0_1111;
`ifdef RFFT_CTRL_BITREV_EN
  localparam logic [11:0] AW0 = 12'hCA0;
  localparam logic [11:0] AW1 = 12'hEE9;
`else
  localparam logic [11:0] AW0 = 12'h688;
  localparam logic [11:0] AW1 = 12'hFAC;
`endif

  exp_t obs;
  assign obs = {busy, done, rd_en, addr_read, wr_en, addr_write,
                m0, m11, m12, m13, m14, m21, m22, m23, m24, bypass_en, tw_idx};

  exp_t  tbl [0:39];
  exp_t  sb [$];
  string sb_tag [$];
  int    n_run = 0, n_fail = 0;

  function automatic exp_t mk(input logic b, d, r, input logic [11:0] ar,
                              input logic w, input logic [11:0] aw,
                              input logic [10:0] sel, input logic byp, input logic [1:0] tw);
    exp_t e;
    e = '{busy:b, done:d, rd:r, ar:ar, wr:w, aw:aw, sel:sel, byp:byp, tw:tw};
    return e;
  endfunction

  task automatic check(input string nm, input exp_t got, input exp_t exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) check(sb_tag.pop_front(), obs, sb.pop_front());
  end

  // Drive one frame starting at edge 0; push n expected records (c1..cn) from tbl[first].
  task automatic run_frame(input string nm, input int first, input int n, input logic byp,
                           input int rs_a, input int rs_b, input int ab_c);
    @(posedge clk); #1;
    start = 1'b1; bypass = byp;
    @(posedge clk); #1;
    start = 1'b0; bypass = 1'b0;
    for (int i = 0; i < n; i++) begin
      sb.push_back(tbl[first+i]);
      sb_tag.push_back($sformatf("%s_c%0d", nm, i + 1));
    end
    for (int c = 1; c <= n; c++) begin
      start = (c == rs_a || c == rs_b);
      abort = (c == ab_c);
      @(posedge clk); #1;
    end
    start = 1'b0; abort = 1'b0;
  endtask

  initial begin
    exp_t z;
    z = '0;
    // Normal frame c1..c10 at tbl[0..9]
    tbl[0] = mk(1,0,1,12'h688,0,12'h0,11'h0,0,2'd0);
    tbl[1] = mk(1,0,0,12'h0,0,12'h0,SEL_S1,0,2'd0);
    tbl[2] = mk(1,0,0,12'h0,0,12'h0,SEL_S2,0,2'd0);
    tbl[3] = mk(1,0,0,12'h0,1,AW0,11'h0,0,2'd0);
    tbl[4] = mk(1,0,1,12'hFAC,0,12'h0,11'h0,0,2'd0);
    tbl[5] = mk(1,0,0,12'h0,0,12'h0,SEL_S1,0,2'd0);
    tbl[6] = mk(1,0,0,12'h0,0,12'h0,SEL_S2,0,2'd1);
    tbl[7] = mk(1,0,0,12'h0,1,AW1,11'h0,0,2'd0);
    tbl[8] = mk(1,1,0,12'h0,0,12'h0,11'h0,0,2'd0);
    tbl[9] = z;
    // Bypass frame at tbl[10..19]
    tbl[10] = mk(1,0,1,12'h688,0,12'h0,11'h0,0,2'd0);
    tbl[11] = mk(1,0,0,12'h0,0,12'h0,11'h0,1,2'd0);
    tbl[12] = mk(1,0,0,12'h0,0,12'h0,11'h0,1,2'd0);
    tbl[13] = mk(1,0,0,12'h0,1,AW0,11'h0,1,2'd0);
    tbl[14] = mk(1,0,1,12'hFAC,0,12'h0,11'h0,0,2'd0);
    tbl[15] = mk(1,0,0,12'h0,0,12'h0,11'h0,1,2'd0);
    tbl[16] = mk(1,0,0,12'h0,0,12'h0,11'h0,1,2'd0);
    tbl[17] = mk(1,0,0,12'h0,1,AW1,11'h0,1,2'd0);
    tbl[18] = mk(1,1,0,12'h0,0,12'h0,11'h0,0,2'd0);
    tbl[19] = z;
    // Abort in c3 at tbl[20..25]: IDLE from c4, no write, no done
    tbl[20] = tbl[0];
    tbl[21] = tbl[1];
    tbl[22] = tbl[2];
    tbl[23] = z;
    tbl[24] = z;
    tbl[25] = z;
    for (int i = 26; i < 40; i++) tbl[i] = z;

    rst_n = 1'b0; start = 1'b0; bypass = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("reset_hold", obs, z);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1 check("reset_idle", obs, z);

    run_frame("normal", 0, 10, 1'b0, 0, 0, 0);
    run_frame("bypass", 10, 10, 1'b1, 0, 0, 0);
    run_frame("restart", 0, 10, 1'b0, 3, 6, 0);
    run_frame("abort", 20, 6, 1'b0, 0, 0, 3);
    run_frame("after_abort", 0, 10, 1'b0, 0, 0, 0);

    // start and abort together in IDLE: stay idle
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    sb.push_back(z); sb_tag.push_back("start_abort_c1");
    @(posedge clk); #1;
    sb.push_back(z); sb_tag.push_back("start_abort_c2");
    @(posedge clk); #1;

    // Asynchronous reset mid-frame, applied between clock edges
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_busy", obs, tbl[1]);
    #2 rst_n = 1'b0;
    #1 check("async_reset", obs, z);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1 check("post_reset_idle", obs, z);

    run_frame("post_reset", 0, 10, 1'b0, 0, 0, 0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    n_run++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d entries left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
